// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats
// and the ID/EX pipeline register layout.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] rs1_data;
    logic [RV_XLEN-1:0] rs2_data;
    logic [RV_XLEN-1:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    alu_op_t            alu_op;
    logic               alu_src_imm;
    logic               alu_src_pc;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         funct3;
    logic               reg_write;
    logic               branch;
    logic               jump;
    logic               jalr;
    logic               illegal;
  } id_ex_t;

  function automatic logic [RV_XLEN-1:0] imm_gen(imm_fmt_t fmt, logic [31:0] ins);
    case (fmt)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  // Shared by OP and OP-IMM; alt is funct7[5], sub_ok is false for OP-IMM.
  function automatic alu_op_t alu_from_funct3(logic [2:0] f3, logic alt, logic sub_ok);
    case (f3)
      3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX bundle from decode to execute; decode drives the master side.
interface decode_stage_if
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  alu_op_t         ex_alu_op;
  logic            ex_alu_src_imm;
  logic            ex_alu_src_pc;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [2:0]      ex_funct3;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jalr;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write,
           ex_funct3, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal
  );

  modport slave (
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write,
           ex_funct3, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal
  );
endinterface

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports with write-through,
// one synchronous write port, x0 hardwired to zero.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the register array is reset because architectural state must read
  // zero after reset; a plain RAM macro without reset would not satisfy that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass the write port so decode captures a value retiring this cycle.
  assign rdata1 = (raddr1 == '0)              ? '0    :
                  (we && waddr == raddr1)     ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0)              ? '0    :
                  (we && waddr == raddr2)     ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode: control/immediate decode, register read,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instruction_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  decode_stage_if.master  ex
);

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            funct7_5;
  imm_fmt_t        fmt;
  logic [4:0]      rs1_used, rs2_used;
  logic [XLEN-1:0] rs1_data, rs2_data;
  id_ex_t          dec, id_ex_d, id_ex_q;

  assign opcode   = instruction_in[6:0];
  assign rd       = instruction_in[11:7];
  assign funct3   = instruction_in[14:12];
  assign rs1      = instruction_in[19:15];
  assign rs2      = instruction_in[24:20];
  assign funct7_5 = instruction_in[30];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dec          = '0;
    fmt          = IMM_NONE;
    rs1_used     = '0;
    rs2_used     = '0;
    dec.valid    = 1'b1;
    dec.pc       = pc_in;
    dec.funct3   = funct3;
    case (opcode)
      OPC_LUI: begin
        fmt = IMM_U; dec.rd = rd; dec.reg_write = 1'b1;
        dec.alu_op = ALU_PASSB; dec.alu_src_imm = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = IMM_U; dec.rd = rd; dec.reg_write = 1'b1;
        dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1;
      end
      OPC_JAL: begin
        fmt = IMM_J; dec.rd = rd; dec.reg_write = 1'b1; dec.jump = 1'b1;
        dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1;
      end
      OPC_JALR: begin
        fmt = IMM_I; dec.rd = rd; rs1_used = rs1; dec.reg_write = 1'b1;
        dec.jump = 1'b1; dec.jalr = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = IMM_B; rs1_used = rs1; rs2_used = rs2;
        dec.branch = 1'b1; dec.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        fmt = IMM_I; dec.rd = rd; rs1_used = rs1; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        fmt = IMM_S; rs1_used = rs1; rs2_used = rs2;
        dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt = IMM_I; dec.rd = rd; rs1_used = rs1; dec.reg_write = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, funct7_5 && funct3 == 3'b101, 1'b0);
      end
      OPC_OP: begin
        dec.rd = rd; rs1_used = rs1; rs2_used = rs2; dec.reg_write = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, funct7_5, 1'b1);
      end
      default: begin
        dec.illegal = 1'b1;
        dec.funct3  = '0;
      end
    endcase
    dec.imm = imm_gen(fmt, instruction_in);
    dec.rs1 = rs1_used;
    dec.rs2 = rs2_used;
    // All-zero word is the fetch reset value, not an illegal instruction.
    if (instruction_in == '0) dec = '0;
  end

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1_used),
    .raddr2 (rs2_used),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // Uses only ID/EX state and the decoded source indices: no path from wb_*.
  assign stall = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                 ((id_ex_q.rd == rs1_used) || (id_ex_q.rd == rs2_used)) && !flush;

  always_comb begin
    id_ex_d          = dec;
    id_ex_d.rs1_data = rs1_data;
    id_ex_d.rs2_data = rs2_data;
    if (flush || stall) id_ex_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign ex.ex_valid       = id_ex_q.valid;
  assign ex.ex_pc          = id_ex_q.pc;
  assign ex.ex_rs1_data    = id_ex_q.rs1_data;
  assign ex.ex_rs2_data    = id_ex_q.rs2_data;
  assign ex.ex_imm         = id_ex_q.imm;
  assign ex.ex_rs1         = id_ex_q.rs1;
  assign ex.ex_rs2         = id_ex_q.rs2;
  assign ex.ex_rd          = id_ex_q.rd;
  assign ex.ex_alu_op      = id_ex_q.alu_op;
  assign ex.ex_alu_src_imm = id_ex_q.alu_src_imm;
  assign ex.ex_alu_src_pc  = id_ex_q.alu_src_pc;
  assign ex.ex_mem_read    = id_ex_q.mem_read;
  assign ex.ex_mem_write   = id_ex_q.mem_write;
  assign ex.ex_funct3      = id_ex_q.funct3;
  assign ex.ex_reg_write   = id_ex_q.reg_write;
  assign ex.ex_branch      = id_ex_q.branch;
  assign ex.ex_jump        = id_ex_q.jump;
  assign ex.ex_jalr        = id_ex_q.jalr;
  assign ex.ex_illegal     = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// instruction streams compared against a field-level reference model.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instruction_in, wb_data;
  logic        flush, wb_en;
  logic [4:0]  wb_rd;
  logic        stall;

  decode_stage_if ex_if ();

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .instruction_in (instruction_in),
    .flush          (flush),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .stall          (stall),
    .ex             (ex_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference state: architectural registers and the expected ID/EX contents.
  logic [31:0] m_regs [32];
  id_ex_t      m_ex;

  function automatic logic [31:0] m_read(logic [4:0] r, logic we, logic [4:0] wr, logic [31:0] wd);
    if (r == 0) return 0;
    if (we && wr == r) return wd;
    return m_regs[r];
  endfunction

  // Decode from the ISA tables using signed arithmetic for the immediates.
  function automatic id_ex_t m_decode(logic [31:0] ins, logic [31:0] pc,
                                      logic we, logic [4:0] wr, logic [31:0] wd);
    id_ex_t  e;
    int      sgn, imm_i, imm_s, imm_b, imm_j;
    alu_op_t tbl [8];
    logic    use_rs1, use_rs2, use_rd;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    e = '0;
    if (ins == 0) return e;
    sgn   = ins[31] ? -1 : 0;
    imm_i = $signed(ins) >>> 20;
    imm_s = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
    imm_b = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    imm_j = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    use_rs1 = 0; use_rs2 = 0; use_rd = 0;
    e.valid = 1; e.pc = pc; e.funct3 = ins[14:12]; e.alu_op = ALU_ADD;
    case (ins[6:0])
      7'h37: begin use_rd = 1; e.imm = ins & 32'hFFFFF000; e.alu_op = ALU_PASSB; e.alu_src_imm = 1; end
      7'h17: begin use_rd = 1; e.imm = ins & 32'hFFFFF000; e.alu_src_imm = 1; e.alu_src_pc = 1; end
      7'h6F: begin use_rd = 1; e.imm = imm_j; e.jump = 1; e.alu_src_imm = 1; e.alu_src_pc = 1; end
      7'h67: begin use_rd = 1; use_rs1 = 1; e.imm = imm_i; e.jump = 1; e.jalr = 1; e.alu_src_imm = 1; end
      7'h63: begin use_rs1 = 1; use_rs2 = 1; e.imm = imm_b; e.branch = 1; e.alu_op = ALU_SUB; end
      7'h03: begin use_rd = 1; use_rs1 = 1; e.imm = imm_i; e.mem_read = 1; e.alu_src_imm = 1; end
      7'h23: begin use_rs1 = 1; use_rs2 = 1; e.imm = imm_s; e.mem_write = 1; e.alu_src_imm = 1; end
      7'h13: begin
        use_rd = 1; use_rs1 = 1; e.imm = imm_i; e.alu_src_imm = 1;
        e.alu_op = (ins[14:12] == 5 && ins[30]) ? ALU_SRA : tbl[ins[14:12]];
      end
      7'h33: begin
        use_rd = 1; use_rs1 = 1; use_rs2 = 1;
        e.alu_op = tbl[ins[14:12]];
        if (ins[30] && ins[14:12] == 0) e.alu_op = ALU_SUB;
        if (ins[30] && ins[14:12] == 5) e.alu_op = ALU_SRA;
      end
      default: begin
        e = '0; e.valid = 1; e.pc = pc; e.illegal = 1;
        return e;
      end
    endcase
    e.reg_write = use_rd;
    if (use_rd)  e.rd  = ins[11:7];
    if (use_rs1) e.rs1 = ins[19:15];
    if (use_rs2) e.rs2 = ins[24:20];
    e.rs1_data = m_read(e.rs1, we, wr, wd);
    e.rs2_data = m_read(e.rs2, we, wr, wd);
    return e;
  endfunction

  task automatic compare_ex();
    check("ex_valid",       ex_if.ex_valid,       m_ex.valid);
    check("ex_pc",          ex_if.ex_pc,          m_ex.pc);
    check("ex_rs1_data",    ex_if.ex_rs1_data,    m_ex.rs1_data);
    check("ex_rs2_data",    ex_if.ex_rs2_data,    m_ex.rs2_data);
    check("ex_imm",         ex_if.ex_imm,         m_ex.imm);
    check("ex_rs1",         ex_if.ex_rs1,         m_ex.rs1);
    check("ex_rs2",         ex_if.ex_rs2,         m_ex.rs2);
    check("ex_rd",          ex_if.ex_rd,          m_ex.rd);
    check("ex_alu_op",      ex_if.ex_alu_op,      m_ex.alu_op);
    check("ex_alu_src_imm", ex_if.ex_alu_src_imm, m_ex.alu_src_imm);
    check("ex_alu_src_pc",  ex_if.ex_alu_src_pc,  m_ex.alu_src_pc);
    check("ex_mem_read",    ex_if.ex_mem_read,    m_ex.mem_read);
    check("ex_mem_write",   ex_if.ex_mem_write,   m_ex.mem_write);
    check("ex_funct3",      ex_if.ex_funct3,      m_ex.funct3);
    check("ex_reg_write",   ex_if.ex_reg_write,   m_ex.reg_write);
    check("ex_branch",      ex_if.ex_branch,      m_ex.branch);
    check("ex_jump",        ex_if.ex_jump,        m_ex.jump);
    check("ex_jalr",        ex_if.ex_jalr,        m_ex.jalr);
    check("ex_illegal",     ex_if.ex_illegal,     m_ex.illegal);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_ex = '0;
  endtask

  // One ID cycle: drive at negedge, check stall mid-cycle, check ID/EX after the edge.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       output logic st_obs);
    id_ex_t nxt;
    logic   exp_stall;
    @(negedge clk);
    instruction_in = ins; pc_in = pc; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    nxt = m_decode(ins, pc, we, wr, wd);
    exp_stall = m_ex.valid && m_ex.mem_read && m_ex.rd != 0 &&
                (m_ex.rd == nxt.rs1 || m_ex.rd == nxt.rs2) && !fl;
    st_obs = stall;
    check("stall", stall, exp_stall);
    if (fl || exp_stall) nxt = '0;
    @(posedge clk);
    #1;
    if (we && wr != 0) m_regs[wr] = wd;
    m_ex = nxt;
    compare_ex();
    st_obs = exp_stall;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int          kind;
    ins  = $urandom;
    kind = $urandom_range(0, 11);
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    case (kind)
      0:       ins[6:0] = 7'h37;
      1:       ins[6:0] = 7'h17;
      2:       ins[6:0] = 7'h6F;
      3:       ins[6:0] = 7'h67;
      4:       ins[6:0] = 7'h63;
      5, 6:    ins[6:0] = 7'h03;
      7:       ins[6:0] = 7'h23;
      8:       ins[6:0] = 7'h13;
      9:       begin ins[6:0] = 7'h33; ins[31:25] = {1'b0, ins[30], 5'b0}; end
      10:      ins[6:0] = 7'h73;
      default: ins = 0;
    endcase
    return ins;
  endfunction

  logic        st;
  logic [31:0] cur_ins, cur_pc;

  initial begin
    reset = 1'b1; pc_in = 0; instruction_in = 0; flush = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
    model_reset();
    #12;
    compare_ex();
    check("reset_stall", stall, 0);
    @(negedge clk) reset = 1'b0;

    // ADDI x2,x0,1
    cycle(32'h00100113, 32'h100, 0, 0, 0, 0, st);
    check("addi_valid", ex_if.ex_valid, 1);
    check("addi_rd", ex_if.ex_rd, 2);
    check("addi_imm", ex_if.ex_imm, 1);
    check("addi_alu", ex_if.ex_alu_op, ALU_ADD);
    check("addi_src_imm", ex_if.ex_alu_src_imm, 1);
    check("addi_reg_write", ex_if.ex_reg_write, 1);
    check("addi_rs1_data", ex_if.ex_rs1_data, 0);

    // Preload x1=10, x2=3 through writeback, then SUB x7,x1,x2
    cycle(0, 0, 0, 1, 1, 10, st);
    cycle(0, 0, 0, 1, 2, 3, st);
    cycle(32'h402083B3, 32'h104, 0, 0, 0, 0, st);
    check("sub_alu", ex_if.ex_alu_op, ALU_SUB);
    check("sub_rs1_data", ex_if.ex_rs1_data, 10);
    check("sub_rs2_data", ex_if.ex_rs2_data, 3);
    check("sub_rd", ex_if.ex_rd, 7);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x5
    cycle(32'h0000A283, 32'h108, 0, 0, 0, 0, st);
    cycle(32'h00528333, 32'h10C, 0, 0, 0, 0, st);
    check("lu_stall_first", st, 1);
    check("lu_bubble_valid", ex_if.ex_valid, 0);
    cycle(32'h00528333, 32'h10C, 0, 0, 0, 0, st);
    check("lu_stall_second", st, 0);
    check("lu_add_valid", ex_if.ex_valid, 1);
    check("lu_add_rs1", ex_if.ex_rs1, 5);
    check("lu_add_rs2", ex_if.ex_rs2, 5);
    cycle(32'h0000A283, 32'h110, 0, 0, 0, 0, st);
    cycle(32'h00000013, 32'h114, 0, 0, 0, 0, st);
    check("lu_nop_stall", st, 0);

    // Write-through on x3, then a write to x0 that must not stick
    cycle(32'h00018233, 32'h118, 0, 1, 3, 32'hDEADBEEF, st);
    check("wt_rs1_data", ex_if.ex_rs1_data, 32'hDEADBEEF);
    cycle(32'h00000233, 32'h11C, 0, 1, 0, 32'hDEADBEEF, st);
    check("wt_x0_same", ex_if.ex_rs1_data, 0);
    cycle(32'h00000233, 32'h120, 0, 0, 0, 0, st);
    check("wt_x0_after", ex_if.ex_rs1_data, 0);

    // Flush during a load-use hazard
    cycle(32'h0000A283, 32'h124, 0, 0, 0, 0, st);
    cycle(32'h00528333, 32'h128, 1, 0, 0, 0, st);
    check("flush_stall", st, 0);
    check("flush_valid", ex_if.ex_valid, 0);
    check("flush_reg_write", ex_if.ex_reg_write, 0);

    // Reset asserted mid-stall
    cycle(32'h0000A283, 32'h12C, 0, 0, 0, 0, st);
    @(negedge clk);
    instruction_in = 32'h00528333; pc_in = 32'h130; flush = 0; wb_en = 0;
    #1;
    check("rst_pre_stall", stall, 1);
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_ex();
    check("rst_stall", stall, 0);
    @(negedge clk) reset = 1'b0;
    cycle(32'h00008233, 32'h134, 0, 0, 0, 0, st);
    check("rst_x1_cleared", ex_if.ex_rs1_data, 0);

    // Random instruction stream with a holding fetch model
    cur_pc  = 32'h1000;
    cur_ins = gen_instr();
    for (int n = 0; n < 400; n++) begin
      logic fl;
      fl = ($urandom_range(0, 9) == 0);
      cycle(cur_ins, cur_pc, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, st);
      if (fl) begin
        cur_pc  = $urandom & 32'hFFFFFFFC;
        cur_ins = gen_instr();
      end else if (!st) begin
        cur_pc  = cur_pc + 4;
        cur_ins = gen_instr();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
